// File: rtl/brc_pkg.sv
// Shared types and defaults for the branch resolution controller.
// The queue entry carries the fall-through PC at the widest supported width
// (64 bits); instances with a narrower XLEN zero-extend on push and truncate on read.
package brc_pkg;

    localparam int BRC_DEPTH_DEF = 4;
    localparam int BRC_PC_MAX_W  = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } brc_state_e;

    typedef struct packed {
        logic                    pred_taken;
        logic [BRC_PC_MAX_W-1:0] pred_pc4;
    } brc_entry_t;

endpackage

// File: rtl/brc_fifo.sv
// In-flight prediction queue: circular buffer of brc_entry_t.
// Pointers wrap naturally because DEPTH is a power of two. clear_i empties the
// queue and wins over a same-cycle push or pop.
module brc_fifo
    import brc_pkg::*;
#(
    parameter int DEPTH = BRC_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  brc_entry_t din_i,
    input  logic       pop_i,
    input  logic       clear_i,
    output logic       full_o,
    output logic       empty_o,
    output brc_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push;
    logic             do_pop;
    brc_entry_t       mem_q [DEPTH];

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointer/occupancy; a push into a full queue is dropped even if a pop happens too
    always_comb begin
        do_push  = push_i && !full_o && !clear_i;
        do_pop   = pop_i && !empty_o && !clear_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    // Control state: pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage; contents are only meaningful while occupied, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: queues IF predictions, checks them against EX
// outcomes, issues a one-cycle flush with the corrected fetch PC on a mispredict,
// and strobes a predictor update one cycle after each accepted resolution.
// Optional statistics counters are built when BRC_STATS_EN is defined;
// otherwise branch_count/mispredict_count are tied to zero.
// XLEN must not exceed 64.
module branch_resolve_ctrl
    import brc_pkg::*;
#(
    parameter int DEPTH = BRC_DEPTH_DEF,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_pc4,
    input  logic             branchex,
    input  logic             outcome,
    input  logic [XLEN-1:0]  ex_target,
    output logic             stall_if,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic             upd_outcome,
    output logic             err_underflow,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    brc_state_e      state_q, state_d;
    logic            in_idle;
    logic            acc_br;
    logic            mispredict;
    logic            head_taken;
    logic            q_full;
    logic            q_empty;
    brc_entry_t      push_s;
    brc_entry_t      head_s;

    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            upd_valid_q, upd_valid_d;
    logic            upd_outcome_q, upd_outcome_d;
    logic            err_underflow_q, err_underflow_d;

    // Resolutions and pushes during FLUSH belong to the wrong path and are ignored.
    // An empty queue at resolution time is treated as a not-taken prediction.
    assign in_idle    = (state_q == ST_IDLE);
    assign acc_br     = branchex && in_idle;
    assign head_taken = q_empty ? 1'b0 : head_s.pred_taken;
    assign mispredict = acc_br && (head_taken != outcome);
    assign stall_if   = q_full;

    // Widen the fall-through PC into the queue entry
    always_comb begin
        push_s.pred_taken = pred_taken;
        push_s.pred_pc4   = BRC_PC_MAX_W'(pred_pc4);
    end

    brc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pred_valid && in_idle),
        .din_i   (push_s),
        .pop_i   (acc_br),
        .clear_i (mispredict),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (head_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: FLUSH lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mispredict) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output: the flush pulse is the FLUSH state itself, so reset drops it at once
    always_comb begin
        flush = (state_q == ST_FLUSH);
    end

    // Next redirect PC, predictor update strobe and sticky underflow flag
    always_comb begin
        redirect_pc_d   = redirect_pc_q;
        upd_valid_d     = acc_br;
        upd_outcome_d   = upd_outcome_q;
        err_underflow_d = err_underflow_q;
        if (mispredict) redirect_pc_d = outcome ? ex_target : XLEN'(head_s.pred_pc4);
        if (acc_br) upd_outcome_d = outcome;
        if (acc_br && q_empty) err_underflow_d = 1'b1;
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_pc_q   <= '0;
            upd_valid_q     <= 1'b0;
            upd_outcome_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            redirect_pc_q   <= redirect_pc_d;
            upd_valid_q     <= upd_valid_d;
            upd_outcome_q   <= upd_outcome_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign redirect_pc   = redirect_pc_q;
    assign upd_valid     = upd_valid_q;
    assign upd_outcome   = upd_outcome_q;
    assign err_underflow = err_underflow_q;

`ifdef BRC_STATS_EN
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // Saturating statistics increments
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (acc_br && (branch_count_q != '1))
            branch_count_d = branch_count_q + CNT_W'(1);
        if (mispredict && (mispredict_count_q != '1))
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    // Statistics counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl (DEPTH 4, XLEN 32, CNT_W 16).
module tb_branch_resolve_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
`ifdef BRC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             pred_valid, pred_taken, branchex, outcome;
    logic [XLEN-1:0]  pred_pc4, ex_target;
    logic             stall_if, flush, upd_valid, upd_outcome, err_underflow;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [XLEN-1:0] exp_flush_q [$];
    logic            exp_upd_q   [$];

    branch_resolve_ctrl #(.DEPTH(4), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_pc4         (pred_pc4),
        .branchex         (branchex),
        .outcome          (outcome),
        .ex_target        (ex_target),
        .stall_if         (stall_if),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_outcome      (upd_outcome),
        .err_underflow    (err_underflow),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; returns at posedge+1 with inputs idle
    task automatic step(input logic pv, input logic pt, input logic [XLEN-1:0] pc4,
                        input logic bx, input logic oc, input logic [XLEN-1:0] tgt);
        pred_valid = pv; pred_taken = pt; pred_pc4 = pc4;
        branchex = bx; outcome = oc; ex_target = tgt;
        @(posedge clk); #1;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_pc4 = '0;
        branchex = 1'b0; outcome = 1'b0; ex_target = '0;
    endtask

    task automatic push(input logic pt, input logic [XLEN-1:0] pc4);
        step(1'b1, pt, pc4, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_counts(input string tag, input int bc, input int mc);
        chk({tag, "_branch_count"}, 64'(branch_count), STATS ? 64'(bc) : 64'd0);
        chk({tag, "_mispredict_count"}, 64'(mispredict_count), STATS ? 64'(mc) : 64'd0);
    endtask

    // Monitor: every output pulse must match the next queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (upd_valid) begin
                if (exp_upd_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_upd_valid: got outcome %0b expected no pulse", upd_outcome);
                end else begin
                    chk("upd_outcome", 64'(upd_outcome), 64'(exp_upd_q.pop_front()));
                end
            end
            if (flush) begin
                if (exp_flush_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_flush: got redirect 0x%0h expected no pulse", redirect_pc);
                end else begin
                    chk("redirect_pc", 64'(redirect_pc), 64'(exp_flush_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_pc4 = '0;
        branchex = 1'b0; outcome = 1'b0; ex_target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall_if", 64'(stall_if), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_err_underflow", 64'(err_underflow), 64'd0);
        chk_counts("rst", 0, 0);
        reset = 1'b0;
        idle();

        // Correct taken prediction: update only, no flush
        push(1'b1, 32'h104);
        exp_upd_q.push_back(1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h999);
        idle();
        chk_counts("t1", 1, 0);

        // Not-taken predicted, taken resolved; same-cycle push is discarded
        push(1'b0, 32'h204);
        exp_upd_q.push_back(1'b1);
        exp_flush_q.push_back(32'h400);
        step(1'b1, 1'b1, 32'h2FF, 1'b1, 1'b1, 32'h400);
        idle();
        chk_counts("t2", 2, 1);

        // Taken predicted, not-taken resolved with two younger entries; FLUSH ignores inputs
        push(1'b1, 32'h304);
        push(1'b0, 32'h308);
        push(1'b0, 32'h30C);
        exp_upd_q.push_back(1'b0);
        exp_flush_q.push_back(32'h304);
        step(1'b1, 1'b1, 32'h310, 1'b1, 1'b0, 32'h888);
        step(1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h777);
        chk_counts("t3", 3, 2);

        // Fill to DEPTH; leftover entries from earlier would raise stall_if early
        push(1'b1, 32'h600);
        push(1'b1, 32'h604);
        push(1'b1, 32'h608);
        chk("fill3_stall_if", 64'(stall_if), 64'd0);
        push(1'b1, 32'h60C);
        chk("fill4_stall_if", 64'(stall_if), 64'd1);
        exp_upd_q.push_back(1'b1);
        step(1'b1, 1'b1, 32'h610, 1'b1, 1'b1, 32'h600);
        chk("pop_stall_if", 64'(stall_if), 64'd0);
        for (int i = 0; i < 3; i++) begin
            exp_upd_q.push_back(1'b1);
            step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h600);
        end
        chk("drained_err_underflow", 64'(err_underflow), 64'd0);

        // Resolution on an empty queue: predicted not-taken, resolved taken
        exp_upd_q.push_back(1'b1);
        exp_flush_q.push_back(32'h700);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h700);
        chk("underflow_err", 64'(err_underflow), 64'd1);
        idle();
        idle();
        chk("underflow_sticky", 64'(err_underflow), 64'd1);
        chk_counts("t5", 8, 3);

        // Reset while flushing
        push(1'b0, 32'h800);
        exp_upd_q.push_back(1'b1);
        exp_flush_q.push_back(32'h900);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h900);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rstflush_flush", 64'(flush), 64'd0);
        chk("rstflush_upd_valid", 64'(upd_valid), 64'd0);
        chk("rstflush_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rstflush_upd_outcome", 64'(upd_outcome), 64'd0);
        chk("rstflush_err_underflow", 64'(err_underflow), 64'd0);
        chk_counts("rstflush", 0, 0);
        @(posedge clk); #1;
        chk("rsthold_flush", 64'(flush), 64'd0);
        reset = 1'b0;
        idle();
        idle();

        chk("left_exp_upd", 64'(exp_upd_q.size()), 64'd0);
        chk("left_exp_flush", 64'(exp_flush_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight prediction queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port pred_valid  in  1  IF issued a branch prediction this cycle.
REQ-007 SHALL have port pred_taken  in  1  predictor output for that branch.
REQ-008 SHALL have port pred_pc4  in  XLEN  fall-through PC (branch PC + 4).
REQ-009 SHALL have port branchex  in  1  branch resolved in EX this cycle.
REQ-010 SHALL have port outcome  in  1  resolved direction, 1 = taken.
REQ-011 SHALL have port ex_target  in  XLEN  resolved taken target.
REQ-012 SHALL have port stall_if  out  1  queue full; IF holds.
REQ-013 SHALL have port flush  out  1  one-cycle mispredict flush pulse.
REQ-014 SHALL have port redirect_pc  out  XLEN  correct fetch PC, valid while flush = 1.
REQ-015 SHALL have port upd_valid  out  1  predictor update strobe, drives predictor branchex.
REQ-016 SHALL have port upd_outcome  out  1  outcome to train predictor.
REQ-017 SHALL have port err_underflow  out  1  sticky: branchex seen with empty queue.
REQ-018 SHALL have ports branch_count, mispredict_count  out  CNT_W  statistics (see Configuration).

Function
REQ-019 SHALL hold a FIFO of {pred_taken, pred_pc4}; push on pred_valid when not full and state IDLE.
REQ-020 SHALL assert stall_if combinationally = (count == DEPTH); push while full is dropped, even with a same-cycle pop.
REQ-021 SHALL pop head on branchex in IDLE; simultaneous push+pop (not full) keeps count unchanged.
REQ-022 SHALL compare head.pred_taken with outcome; mismatch = mispredict.
REQ-023 SHALL, on mispredict, register flush = 1 next cycle with redirect_pc = outcome ? ex_target : head.pred_pc4.
REQ-024 SHALL, on mispredict, clear the whole queue (count = 0) that edge, discarding any same-cycle push.
REQ-025 SHALL implement FSM IDLE -> FLUSH on mispredict; FLUSH -> IDLE unconditionally after one cycle.
REQ-026 SHALL ignore pred_valid and branchex while in FLUSH (wrong-path, no push, no pop, no update).
REQ-027 SHALL register upd_valid = 1, upd_outcome = outcome one cycle after every accepted branchex (latency 1).
REQ-028 SHALL, on branchex with empty queue, treat prediction as not-taken, set err_underflow, still update.
REQ-029 SHALL keep flush, upd_valid single-cycle pulses; redirect_pc holds last value otherwise.
REQ-030 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-031 SHALL, on reset, asynchronously set state IDLE, queue empty, pointers 0, flush 0, redirect_pc 0, upd_valid 0, upd_outcome 0, err_underflow 0, counters 0.
REQ-032 SHALL, on reset mid-flush, drop the pulse immediately; no output pulses while reset = 1.

Configuration
REQ-033 SHALL compile statistics when BRC_STATS_EN is defined: branch_count +1 per accepted branchex, mispredict_count +1 per mispredict, both saturating at all-ones.
REQ-034 SHALL tie branch_count and mispredict_count to 0 with no counter flops when BRC_STATS_EN is undefined.

Structure
REQ-035 SHALL place FSM state enum, queue entry struct and DEPTH default in package brc_pkg.
REQ-036 SHALL implement the queue as sub-module brc_fifo (push, pop, clear, full, empty, head); FSM and update logic in top.

Verification
REQ-037 SHALL cover: push taken, pc4 0x104; branchex outcome 1 -> no flush, upd_valid 1 cycle later, upd_outcome 1, branch_count 1.
REQ-038 SHALL cover: push not-taken pc4 0x204; branchex outcome 1, ex_target 0x400 -> flush 1 cycle, redirect_pc 0x400, queue empty, mispredict_count 1.
REQ-039 SHALL cover: push taken pc4 0x304 plus 2 younger; outcome 0 -> redirect_pc 0x304, count 0, pushes during FLUSH ignored.
REQ-040 SHALL cover: 4 pushes (DEPTH 4) -> stall_if 1; 5th push dropped; pop -> stall_if 0.
REQ-041 SHALL cover: branchex on empty queue, outcome 1 -> err_underflow 1 sticky, flush with redirect ex_target.
REQ-042 SHALL cover: reset asserted during FLUSH -> flush 0 immediately, all outputs at reset values.
